// File: rtl/delay_sequencer.sv
// delay_sequencer: steps the trigger-delay unit through a (delay, width) table.
// Optional WAIT_TRIG watchdog is enabled by defining DELAY_SEQ_TIMEOUT_EN.
module delay_sequencer #(
  parameter int DELAY_BITS     = 32,
  parameter int SEQ_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(SEQ_DEPTH)-1:0] cfg_addr,
  input  logic [DELAY_BITS-1:0]        cfg_delay,
  input  logic [DELAY_BITS-1:0]        cfg_width,
  input  logic [$clog2(SEQ_DEPTH):0]   seq_len,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         ext_trigger,
  input  logic                         du_out,
  output logic [DELAY_BITS-1:0]        du_delay,
  output logic                         du_delay_upd,
  output logic [DELAY_BITS-1:0]        du_width,
  output logic                         du_width_upd,
  output logic                         du_fire,
  output logic                         busy,
  output logic [$clog2(SEQ_DEPTH)-1:0] step_idx,
  output logic                         done,
  output logic                         aborted,
  output logic                         cfg_err,
  output logic                         timeout
);

  localparam int AW = $clog2(SEQ_DEPTH);
  localparam int LW = AW + 1;

  if (SEQ_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("delay_sequencer: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_TRIG, WAIT_PULSE, DONE
  } state_t;

  state_t state, state_n;

  logic [DELAY_BITS-1:0] tbl_delay [SEQ_DEPTH];
  logic [DELAY_BITS-1:0] tbl_width [SEQ_DEPTH];

  logic [LW-1:0]         len_q, len_n;
  logic [AW-1:0]         idx_n;
  logic [DELAY_BITS-1:0] delay_n, width_n;
  logic                  upd_n, fire_n, done_n, tmo_n;
  logic                  load, last, du_prev, tmo_hit;

  assign last = (LW'(step_idx) == len_q - LW'(1));

`ifdef DELAY_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else if (state != WAIT_TRIG) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Table has no reset; host writes only land while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      tbl_delay[cfg_addr] <= cfg_delay;
      tbl_width[cfg_addr] <= cfg_width;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = step_idx;
    len_n   = len_q;
    delay_n = du_delay;
    width_n = du_width;
    upd_n   = 1'b0;
    fire_n  = 1'b0;
    done_n  = 1'b0;
    tmo_n   = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm && !abort) begin
          if (seq_len == '0) begin
            done_n = 1'b1;
          end else begin
            len_n = (seq_len > LW'(SEQ_DEPTH)) ?
                    LW'(SEQ_DEPTH) : seq_len;
            idx_n   = '0;
            load    = 1'b1;
            state_n = LOAD;
          end
        end
      end
      LOAD: state_n = WAIT_TRIG;
      WAIT_TRIG: begin
        if (ext_trigger) begin
          fire_n  = 1'b1;
          state_n = WAIT_PULSE;
        end else if (tmo_hit) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_PULSE: begin
        if (du_prev && !du_out) begin
          if (last) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            idx_n   = step_idx + AW'(1);
            load    = 1'b1;
            state_n = LOAD;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (load) begin
      upd_n   = 1'b1;
      delay_n = tbl_delay[idx_n];
      width_n = (tbl_width[idx_n] == '0) ?
                DELAY_BITS'(1) : tbl_width[idx_n];
    end
    // Abort overrides any transition taken this cycle.
    if (abort && state != IDLE) begin
      state_n = IDLE;
      idx_n   = '0;
      delay_n = du_delay;
      width_n = du_width;
      upd_n   = 1'b0;
      fire_n  = 1'b0;
      done_n  = 1'b0;
      tmo_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      du_prev      <= 1'b0;
      du_delay     <= '0;
      du_width     <= '0;
      du_delay_upd <= 1'b0;
      du_width_upd <= 1'b0;
      du_fire      <= 1'b0;
      busy         <= 1'b0;
      step_idx     <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      len_q        <= len_n;
      du_prev      <= (state == WAIT_PULSE) && du_out;
      du_delay     <= delay_n;
      du_width     <= width_n;
      du_delay_upd <= upd_n;
      du_width_upd <= upd_n;
      du_fire      <= fire_n;
      busy         <= (state_n != IDLE);
      step_idx     <= idx_n;
      done         <= done_n;
      aborted      <= abort && (state != IDLE);
      cfg_err      <= cfg_we && (state != IDLE);
      timeout      <= tmo_n;
    end
  end

endmodule

// File: tb/tb_delay_sequencer.sv
// tb_delay_sequencer: directed and random campaigns against a step-list model.
// Define DELAY_SEQ_TIMEOUT_EN to build with a 16-cycle watchdog.
module tb_delay_sequencer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef DELAY_SEQ_TIMEOUT_EN
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 2**24;
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_delay = '0;
  logic [DW-1:0] cfg_width = '0;
  logic [AW:0] seq_len = '0;
  logic arm = 1'b0, abort = 1'b0;
  logic ext_trigger = 1'b0, du_out = 1'b0;

  logic [DW-1:0] du_delay, du_width;
  logic du_delay_upd, du_width_upd, du_fire, busy;
  logic [AW-1:0] step_idx;
  logic done, aborted, cfg_err, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delay_sequencer #(
    .DELAY_BITS(DW), .SEQ_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .seq_len(seq_len), .arm(arm), .abort(abort),
    .ext_trigger(ext_trigger), .du_out(du_out),
    .du_delay(du_delay), .du_delay_upd(du_delay_upd),
    .du_width(du_width), .du_width_upd(du_width_upd),
    .du_fire(du_fire), .busy(busy), .step_idx(step_idx),
    .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .timeout(timeout)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: a list of steps walked as load/arm/pulse/finish phases.
  logic [DW-1:0] m_tbl_d [DEPTH];
  logic [DW-1:0] m_tbl_w [DEPTH];
  logic [DW-1:0] m_delay = '0, m_width = '0;
  bit m_busy, m_upd, m_fire, m_done, m_abt, m_err, m_tmo;
  int m_idx, m_len, m_wait;
  bit load_now, need_trig, in_pulse, seen_high, finishing;

  function automatic void m_load(int i);
    m_delay  = m_tbl_d[i];
    m_width  = (m_tbl_w[i] == 0) ? 1 : m_tbl_w[i];
    m_upd    = 1;
    load_now = 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_upd = 0; m_fire = 0; m_done = 0;
      m_abt = 0; m_err = 0; m_tmo = 0;
      m_delay = '0; m_width = '0; m_idx = 0;
      load_now = 0; need_trig = 0; in_pulse = 0;
      finishing = 0; seen_high = 0;
    end else begin
      m_upd = 0; m_fire = 0; m_done = 0; m_abt = 0; m_tmo = 0;
      m_err = cfg_we && m_busy;
      if (!m_busy) begin
        if (arm && !abort) begin
          if (seq_len == 0) m_done = 1;
          else begin
            m_len  = (seq_len > DEPTH) ? DEPTH : int'(seq_len);
            m_idx  = 0;
            m_busy = 1;
            m_load(0);
          end
        end
        if (cfg_we) begin
          m_tbl_d[cfg_addr] = cfg_delay;
          m_tbl_w[cfg_addr] = cfg_width;
        end
      end else if (abort) begin
        m_busy = 0; m_abt = 0 == 0; m_idx = 0;
        load_now = 0; need_trig = 0; in_pulse = 0; finishing = 0;
      end else if (finishing) begin
        finishing = 0; m_busy = 0;
      end else if (load_now) begin
        load_now = 0; need_trig = 1; m_wait = 0;
      end else if (need_trig) begin
        if (ext_trigger) begin
          m_fire = 1; need_trig = 0; in_pulse = 1; seen_high = 0;
        end else begin
          m_wait++;
          if (TMO_EN && m_wait >= TMO) begin
            m_tmo = 1; m_busy = 0; need_trig = 0;
          end
        end
      end else if (in_pulse) begin
        if (seen_high && !du_out) begin
          in_pulse = 0;
          if (m_idx == m_len - 1) begin
            finishing = 1; m_done = 1;
          end else begin
            m_idx++;
            m_load(m_idx);
          end
        end else seen_high = du_out;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("delay_upd", 64'(du_delay_upd), 64'(m_upd));
      chk("width_upd", 64'(du_width_upd), 64'(m_upd));
      chk("fire", 64'(du_fire), 64'(m_fire));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("step_idx", 64'(step_idx), 64'(m_idx));
      chk("done", 64'(done), 64'(m_done));
      chk("aborted", 64'(aborted), 64'(m_abt));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      chk("timeout", 64'(timeout), 64'(m_tmo));
      chk("du_delay", 64'(du_delay), 64'(m_delay));
      chk("du_width", 64'(du_width), 64'(m_width));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    arm = 0; abort = 0; ext_trigger = 0; cfg_we = 0;
  endtask

  task automatic wr(int a, int d, int w);
    cfg_we = 1; cfg_addr = AW'(a);
    cfg_delay = DW'(d); cfg_width = DW'(w);
    tick();
  endtask

  int d2 [3] = '{0, 5, 2};
  int w2 [3] = '{1, 4, 1};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_delay", 64'(du_delay), 64'd0);
    chk("rst_idx", 64'(step_idx), 64'd0);
    chk("rst_fire", 64'(du_fire), 64'd0);
    rst = 0;
    for (int i = 0; i < DEPTH; i++) wr(i, i + 1, i + 1);

    // single step
    wr(0, 3, 2);
    seq_len = 1; arm = 1; tick();
    chk("t1_upd", 64'(du_delay_upd), 64'd1);
    chk("t1_delay", 64'(du_delay), 64'd3);
    chk("t1_width", 64'(du_width), 64'd2);
    tick();
    chk("t1_upd_once", 64'(du_width_upd), 64'd0);
    tick(); tick();
    ext_trigger = 1; tick();
    chk("t1_fire", 64'(du_fire), 64'd1);
    tick();
    chk("t1_fire_once", 64'(du_fire), 64'd0);
    tick(); tick();
    du_out = 1; tick(); tick();
    du_out = 0; tick();
    chk("t1_done", 64'(done), 64'd1);
    tick();
    chk("t1_idle", 64'(busy), 64'd0);

    // three steps in order
    for (int i = 0; i < 3; i++) wr(i, d2[i], w2[i]);
    seq_len = 3; arm = 1; tick();
    for (int s = 0; s < 3; s++) begin
      chk("t2_delay", 64'(du_delay), 64'(d2[s]));
      chk("t2_width", 64'(du_width), 64'(w2[s]));
      chk("t2_idx", 64'(step_idx), 64'(s));
      tick();
      ext_trigger = 1; tick();
      chk("t2_fire", 64'(du_fire), 64'd1);
      tick();
      du_out = 1;
      repeat (w2[s]) tick();
      du_out = 0; tick();
      chk("t2_done", 64'(done), 64'(s == 2));
    end
    tick();

    // dropped triggers and width clamp
    wr(0, 1, 0);
    seq_len = 1; arm = 1; ext_trigger = 1; tick();
    chk("t3_clamp", 64'(du_width), 64'd1);
    ext_trigger = 1; tick();
    chk("t3_load_trig", 64'(du_fire), 64'd0);
    ext_trigger = 1; tick();
    chk("t3_fire", 64'(du_fire), 64'd1);
    ext_trigger = 1; tick();
    chk("t3_pulse_trig", 64'(du_fire), 64'd0);
    du_out = 1; ext_trigger = 1; tick();
    chk("t3_pulse_trig2", 64'(du_fire), 64'd0);
    du_out = 0; tick();
    chk("t3_done", 64'(done), 64'd1);
    tick();

    // abort mid-pulse, then abort beats arm
    seq_len = 2; arm = 1; tick(); tick();
    ext_trigger = 1; tick();
    du_out = 1; tick();
    abort = 1; tick();
    chk("t4_aborted", 64'(aborted), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    du_out = 0; tick();
    chk("t4_no_done", 64'(done), 64'd0);
    abort = 1; arm = 1; seq_len = 1; tick();
    chk("t4_arm_abort", 64'(busy), 64'd0);
    chk("t4_no_pulse", 64'(aborted), 64'd0);

    // write while busy is rejected; zero-length arm
    wr(0, 7, 3);
    seq_len = 1; arm = 1; tick();
    wr(0, 99, 99);
    chk("t5_cfg_err", 64'(cfg_err), 64'd1);
    abort = 1; tick();
    seq_len = 1; arm = 1; tick();
    chk("t5_keep_d", 64'(du_delay), 64'd7);
    chk("t5_keep_w", 64'(du_width), 64'd3);
    abort = 1; tick();
    seq_len = 0; arm = 1; tick();
    chk("t5_len0_done", 64'(done), 64'd1);
    chk("t5_len0_busy", 64'(busy), 64'd0);
    tick();

    // async reset while firing
    seq_len = 2; arm = 1; tick(); tick();
    ext_trigger = 1; tick();
    #2 rst = 1;
    #1;
    chk("rst_mid_fire", 64'(du_fire), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(posedge clk); #1; rst = 0;
    du_out = 1; tick();
    du_out = 0; tick();
    chk("rst_mid_done", 64'(done), 64'd0);

    // watchdog
    seq_len = 1; arm = 1; tick(); tick();
`ifdef DELAY_SEQ_TIMEOUT_EN
    repeat (15) tick();
    chk("t6_early", 64'(timeout), 64'd0);
    tick();
    chk("t6_timeout", 64'(timeout), 64'd1);
    chk("t6_idle", 64'(busy), 64'd0);
`else
    repeat (1000) tick();
    chk("t6_waiting", 64'(busy), 64'd1);
    chk("t6_no_tmo", 64'(timeout), 64'd0);
    abort = 1; tick();
`endif
    tick();

    // random campaigns
    for (int c = 0; c < 60; c++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++)
        wr($urandom_range(0, 7), $urandom_range(0, 20),
           $urandom_range(0, 5));
      seq_len = (AW+1)'($urandom_range(0, 12));
      arm = 1;
      abort = ($urandom_range(0, 15) == 0);
      tick();
      for (int s = 0; s < DEPTH + 1 && m_busy; s++) begin
        repeat ($urandom_range(0, 3)) begin
          ext_trigger = ($urandom_range(0, 4) == 0);
          cfg_we = ($urandom_range(0, 9) == 0);
          cfg_addr = AW'($urandom_range(0, 7));
          cfg_delay = $urandom_range(0, 50);
          cfg_width = $urandom_range(0, 5);
          tick();
        end
        ext_trigger = 1; tick();
        repeat ($urandom_range(0, 4)) begin
          ext_trigger = ($urandom_range(0, 3) == 0);
          tick();
        end
        du_out = 1;
        repeat ($urandom_range(1, 4)) tick();
        du_out = 0;
        abort = ($urandom_range(0, 19) == 0);
        tick();
      end
      repeat (4) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
